instr_decode_ctrl: RTL and testbench

Decode-stage controller that consumes the instruction word and address produced by `prog_memory` and drives that block's control inputs: `jmp_loc`, `pc_mux_sel`, `stall` and `stall_pm`. It does four things:
- latches each fetched instruction;
- decodes it into fields for the execute stage;
- resolves jumps and branches with a one-bubble flush;
- detects load-use hazards and halts.

It sits between program memory and execute, closing the fetch control loop.

---
 rtl/instr_decode_ctrl.sv | 148 ++++++++++++++
 tb/tb_instr_decode_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_ctrl.sv
// Decode-stage controller: latches fetched instructions, decodes them for execute,
// redirects fetch on taken jumps/branches and inserts one bubble per load-use hazard.
module instr_decode_ctrl #(
  parameter int ADDR_W = 16,
  parameter int INS_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INS_W-1:0]  ins,
  input  logic [ADDR_W-1:0] current_address,
  input  logic              zero_flag,
  output logic [ADDR_W-1:0] jmp_loc,
  output logic              pc_mux_sel,
  output logic              stall,
  output logic              stall_pm,
  output logic              d_valid,
  output logic [5:0]        d_opcode,
  output logic [4:0]        d_rd,
  output logic [4:0]        d_rs1,
  output logic [4:0]        d_rs2,
  output logic [15:0]       d_imm,
  output logic [ADDR_W-1:0] d_pc
);

  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_ALU   = 6'h01;
  localparam logic [5:0] OP_ALUI  = 6'h02;
  localparam logic [5:0] OP_LOAD  = 6'h10;
  localparam logic [5:0] OP_STORE = 6'h11;
  localparam logic [5:0] OP_JMP   = 6'h20;
  localparam logic [5:0] OP_BZ    = 6'h21;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  typedef enum logic {RUN, HALTED} state_t;

  state_t            state, state_next;
  logic [INS_W-1:0]  ir;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;

  logic [5:0]  ir_op;
  logic [4:0]  ir_rd, ir_rs1, ir_rs2;
  logic [15:0] ir_imm;
  logic [5:0]  dec_opcode;
  logic        src_match, hazard, is_branch, taken, halt_req, hold;

  assign ir_op  = ir[31:26];
  assign ir_rd  = ir[25:21];
  assign ir_rs1 = ir[20:16];
  assign ir_rs2 = ir[15:11];
  assign ir_imm = ir[15:0];

  // Only the registers an opcode actually reads can create a load-use hazard.
  always_comb begin
    src_match = 1'b0;
    case (ir_op)
      OP_ALU:           src_match = (ir_rs1 == d_rd) || (ir_rs2 == d_rd);
      OP_ALUI, OP_LOAD: src_match = (ir_rs1 == d_rd);
      OP_STORE:         src_match = (ir_rs1 == d_rd) || (ir_rd == d_rd);
      default:          src_match = 1'b0;
    endcase
  end

  always_comb begin
    dec_opcode = OP_NOP;
    if (ir_op inside {OP_NOP, OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_JMP, OP_BZ, OP_HALT})
      dec_opcode = ir_op;
  end

  always_comb begin
    hazard    = (state == RUN) && d_valid && (d_opcode == OP_LOAD) && (d_rd != 5'd0)
                && ir_valid && src_match;
    is_branch = ir_valid && ((ir_op == OP_JMP) || (ir_op == OP_BZ));
    taken     = (state == RUN) && !hazard && ir_valid
                && ((ir_op == OP_JMP) || ((ir_op == OP_BZ) && zero_flag));
    halt_req  = (state == RUN) && !hazard && ir_valid && (ir_op == OP_HALT);
    hold      = (state == HALTED) || hazard;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (halt_req) state_next = HALTED;
  end

  // Reset gates the control outputs so fetch is never redirected or held while clearing.
  always_comb begin
    jmp_loc    = '0;
    pc_mux_sel = 1'b0;
    stall      = 1'b0;
    stall_pm   = 1'b0;
    if (!reset) begin
      if (is_branch) jmp_loc = ADDR_W'(ir_imm);
      pc_mux_sel = taken;
      stall      = hold;
      stall_pm   = hold;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      d_valid  <= 1'b0;
      d_opcode <= '0;
      d_rd     <= '0;
      d_rs1    <= '0;
      d_rs2    <= '0;
      d_imm    <= '0;
      d_pc     <= '0;
    end else if (hold) begin
      d_valid  <= 1'b0;
      d_opcode <= '0;
      d_rd     <= '0;
      d_rs1    <= '0;
      d_rs2    <= '0;
      d_imm    <= '0;
      d_pc     <= '0;
    end else begin
      ir       <= ins;
      ir_pc    <= current_address;
      ir_valid <= ~taken;
      if (ir_valid) begin
        d_valid  <= 1'b1;
        d_opcode <= dec_opcode;
        d_rd     <= ir_rd;
        d_rs1    <= ir_rs1;
        d_rs2    <= ir_rs2;
        d_imm    <= ir_imm;
        d_pc     <= ir_pc;
      end else begin
        d_valid  <= 1'b0;
        d_opcode <= '0;
        d_rd     <= '0;
        d_rs1    <= '0;
        d_rs2    <= '0;
        d_imm    <= '0;
        d_pc     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Self-checking bench for instr_decode_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a slot model.
module tb_instr_decode_ctrl;

  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_ALU   = 6'h01;
  localparam logic [5:0] OP_ALUI  = 6'h02;
  localparam logic [5:0] OP_LOAD  = 6'h10;
  localparam logic [5:0] OP_STORE = 6'h11;
  localparam logic [5:0] OP_JMP   = 6'h20;
  localparam logic [5:0] OP_BZ    = 6'h21;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  logic        clk, reset, zero_flag;
  logic [31:0] ins;
  logic [15:0] current_address;
  logic [15:0] jmp_loc, d_imm, d_pc;
  logic        pc_mux_sel, stall, stall_pm, d_valid;
  logic [5:0]  d_opcode;
  logic [4:0]  d_rd, d_rs1, d_rs2;

  instr_decode_ctrl dut (
    .clk(clk), .reset(reset), .ins(ins), .current_address(current_address),
    .zero_flag(zero_flag), .jmp_loc(jmp_loc), .pc_mux_sel(pc_mux_sel),
    .stall(stall), .stall_pm(stall_pm), .d_valid(d_valid), .d_opcode(d_opcode),
    .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_imm(d_imm), .d_pc(d_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] word;
    logic [15:0] pc;
  } slot_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [15:0] imm, pc;
  } exec_t;

  slot_t       m_ir;
  exec_t       m_ex;
  bit          m_halted;
  logic [15:0] e_jmp;
  bit          e_sel, e_stall;
  int          n_checks, n_fail;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [15:0] low);
    return {op, rd, rs1, low};
  endfunction

  function automatic bit reads_reg(input logic [31:0] w, input logic [4:0] r);
    case (w[31:26])
      OP_ALU:           return (w[20:16] == r) || (w[15:11] == r);
      OP_ALUI, OP_LOAD: return (w[20:16] == r);
      OP_STORE:         return (w[20:16] == r) || (w[25:21] == r);
      default:          return 1'b0;
    endcase
  endfunction

  function automatic bit m_hazard();
    return !m_halted && m_ex.valid && (m_ex.op == OP_LOAD) && (m_ex.rd != 5'd0)
           && m_ir.valid && reads_reg(m_ir.word, m_ex.rd);
  endfunction

  function automatic exec_t decode(input slot_t s);
    exec_t e;
    e.valid = 1'b1;
    e.op    = (s.word[31:26] inside {OP_NOP, OP_ALU, OP_ALUI, OP_LOAD, OP_STORE,
                                     OP_JMP, OP_BZ, OP_HALT}) ? s.word[31:26] : OP_NOP;
    e.rd    = s.word[25:21];
    e.rs1   = s.word[20:16];
    e.rs2   = s.word[15:11];
    e.imm   = s.word[15:0];
    e.pc    = s.pc;
    return e;
  endfunction

  function automatic logic [31:0] randIns();
    int         sel;
    logic [5:0] op;
    sel = $urandom_range(0, 39);
    if      (sel < 3)  op = OP_NOP;
    else if (sel < 10) op = OP_ALU;
    else if (sel < 14) op = OP_ALUI;
    else if (sel < 21) op = OP_LOAD;
    else if (sel < 25) op = OP_STORE;
    else if (sel < 30) op = OP_JMP;
    else if (sel < 36) op = OP_BZ;
    else if (sel < 37) op = OP_HALT;
    else               op = 6'($urandom_range(0, 63));
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 11'($urandom_range(0, 2047))};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic computeExpect();
    logic [5:0] op;
    bit         hz;
    op      = m_ir.word[31:26];
    hz      = m_hazard();
    e_jmp   = (!reset && m_ir.valid && (op == OP_JMP || op == OP_BZ)) ? m_ir.word[15:0] : 16'h0;
    e_sel   = !reset && !m_halted && !hz && m_ir.valid
              && (op == OP_JMP || (op == OP_BZ && zero_flag));
    e_stall = !reset && (m_halted || hz);
  endtask

  task automatic checkOutput();
    check("pc_mux_sel", 32'(pc_mux_sel), 32'(e_sel));
    check("jmp_loc",    32'(jmp_loc),    32'(e_jmp));
    check("stall",      32'(stall),      32'(e_stall));
    check("stall_pm",   32'(stall_pm),   32'(e_stall));
    check("d_valid",    32'(d_valid),    32'(m_ex.valid));
    check("d_opcode",   32'(d_opcode),   32'(m_ex.op));
    check("d_rd",       32'(d_rd),       32'(m_ex.rd));
    check("d_rs1",      32'(d_rs1),      32'(m_ex.rs1));
    check("d_rs2",      32'(d_rs2),      32'(m_ex.rs2));
    check("d_imm",      32'(d_imm),      32'(m_ex.imm));
    check("d_pc",       32'(d_pc),       32'(m_ex.pc));
  endtask

  task automatic stepModel();
    exec_t nx;
    if (reset) begin
      m_halted = 1'b0;
      m_ir     = '0;
      m_ex     = '0;
    end else if (m_halted || m_hazard()) begin
      m_ex = '0;
    end else begin
      nx = m_ir.valid ? decode(m_ir) : exec_t'('0);
      if (m_ir.valid && m_ir.word[31:26] == OP_HALT) m_halted = 1'b1;
      m_ir.valid = !e_sel;
      m_ir.word  = ins;
      m_ir.pc    = current_address;
      m_ex       = nx;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] w, input logic [15:0] a,
                               input bit zf, input bit rst);
    @(negedge clk);
    ins             = w;
    current_address = a;
    zero_flag       = zf;
    reset           = rst;
    #1;
    computeExpect();
    checkOutput();
    stepModel();
  endtask

  logic [31:0] alu;

  initial begin
    reset = 1'b1; ins = '0; current_address = '0; zero_flag = 1'b0;
    m_ir = '0; m_ex = '0; m_halted = 1'b0; n_checks = 0; n_fail = 0;
    alu = mk(OP_ALU, 5'd1, 5'd2, {5'd3, 11'd0});

    // Sequential ALU stream.
    applyStimulus(alu, 16'h0, 1'b0, 1'b1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_sel", 32'(pc_mux_sel), 32'd0);
    for (int a = 0; a < 6; a++) begin
      applyStimulus(alu, 16'(a), 1'b0, 1'b0);
      check("seq_stall", 32'(stall), 32'd0);
      if (a >= 2) begin
        check("seq_valid", 32'(d_valid), 32'd1);
        check("seq_pc", 32'(d_pc), 32'(a - 2));
      end else check("seq_valid0", 32'(d_valid), 32'd0);
    end

    // JMP 0x0008 at 0x0002.
    applyStimulus(alu, 16'h0, 1'b0, 1'b1);
    applyStimulus(alu, 16'h0, 1'b0, 1'b0);
    applyStimulus(alu, 16'h1, 1'b0, 1'b0);
    applyStimulus(mk(OP_JMP, 5'd0, 5'd0, 16'h0008), 16'h2, 1'b0, 1'b0);
    applyStimulus(alu, 16'h3, 1'b0, 1'b0);
    check("jmp_sel", 32'(pc_mux_sel), 32'd1);
    check("jmp_loc", 32'(jmp_loc), 32'h8);
    applyStimulus(alu, 16'h8, 1'b0, 1'b0);
    check("jmp_sel_off", 32'(pc_mux_sel), 32'd0);
    check("jmp_in_ex", 32'(d_opcode), 32'h20);
    applyStimulus(alu, 16'h9, 1'b0, 1'b0);
    check("jmp_flush", 32'(d_valid), 32'd0);
    applyStimulus(alu, 16'hA, 1'b0, 1'b0);
    check("jmp_target_pc", 32'(d_pc), 32'h8);

    // BZ not taken, then taken.
    applyStimulus(alu, 16'h0, 1'b0, 1'b1);
    applyStimulus(mk(OP_BZ, 5'd0, 5'd0, 16'h0010), 16'h0, 1'b0, 1'b0);
    applyStimulus(alu, 16'h1, 1'b0, 1'b0);
    check("bz_nt_sel", 32'(pc_mux_sel), 32'd0);
    check("bz_nt_loc", 32'(jmp_loc), 32'h10);
    applyStimulus(alu, 16'h2, 1'b1, 1'b0);
    check("bz_nt_ex", 32'(d_opcode), 32'h21);
    applyStimulus(mk(OP_BZ, 5'd0, 5'd0, 16'h0010), 16'h3, 1'b0, 1'b0);
    applyStimulus(alu, 16'h4, 1'b1, 1'b0);
    check("bz_t_sel", 32'(pc_mux_sel), 32'd1);
    applyStimulus(alu, 16'h10, 1'b0, 1'b0);
    applyStimulus(alu, 16'h11, 1'b0, 1'b0);
    check("bz_flush", 32'(d_valid), 32'd0);
    applyStimulus(alu, 16'h12, 1'b0, 1'b0);
    check("bz_target_pc", 32'(d_pc), 32'h10);

    // Load-use with rd=5, then rd=0.
    applyStimulus(alu, 16'h0, 1'b0, 1'b1);
    applyStimulus(mk(OP_LOAD, 5'd5, 5'd1, 16'h0), 16'h0, 1'b0, 1'b0);
    applyStimulus(mk(OP_ALU, 5'd1, 5'd2, {5'd5, 11'd0}), 16'h1, 1'b0, 1'b0);
    applyStimulus(alu, 16'h2, 1'b0, 1'b0);
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_stall_pm", 32'(stall_pm), 32'd1);
    applyStimulus(alu, 16'h2, 1'b0, 1'b0);
    check("lu_stall_once", 32'(stall), 32'd0);
    check("lu_bubble", 32'(d_valid), 32'd0);
    applyStimulus(alu, 16'h3, 1'b0, 1'b0);
    check("lu_follow_pc", 32'(d_pc), 32'h1);
    applyStimulus(alu, 16'h0, 1'b0, 1'b1);
    applyStimulus(mk(OP_LOAD, 5'd0, 5'd1, 16'h0), 16'h0, 1'b0, 1'b0);
    applyStimulus(mk(OP_ALU, 5'd1, 5'd2, {5'd0, 11'd0}), 16'h1, 1'b0, 1'b0);
    applyStimulus(alu, 16'h2, 1'b0, 1'b0);
    check("lu_r0_nostall", 32'(stall), 32'd0);
    applyStimulus(alu, 16'h3, 1'b0, 1'b0);
    check("lu_r0_pc", 32'(d_pc), 32'h1);

    // HALT at 0x0004, then reset mid-halt.
    applyStimulus(alu, 16'h0, 1'b0, 1'b1);
    for (int a = 0; a < 4; a++) applyStimulus(alu, 16'(a), 1'b0, 1'b0);
    applyStimulus(mk(OP_HALT, 5'd0, 5'd0, 16'h0), 16'h4, 1'b0, 1'b0);
    applyStimulus(alu, 16'h5, 1'b0, 1'b0);
    check("halt_pre_stall", 32'(stall), 32'd0);
    applyStimulus(alu, 16'h6, 1'b0, 1'b0);
    check("halt_stall", 32'(stall), 32'd1);
    check("halt_in_ex", 32'(d_opcode), 32'h3F);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(alu, 16'h6, 1'b1, 1'b0);
      check("halted_stall_pm", 32'(stall_pm), 32'd1);
      check("halted_valid", 32'(d_valid), 32'd0);
    end
    applyStimulus(alu, 16'h0, 1'b0, 1'b1);
    check("halt_rst_stall", 32'(stall), 32'd0);
    applyStimulus(alu, 16'h0, 1'b0, 1'b0);
    check("post_rst_stall", 32'(stall), 32'd0);
    check("post_rst_valid", 32'(d_valid), 32'd0);
    applyStimulus(alu, 16'h1, 1'b0, 1'b0);
    applyStimulus(alu, 16'h2, 1'b0, 1'b0);
    check("resume_pc", 32'(d_pc), 32'h0);
    check("resume_valid", 32'(d_valid), 32'd1);

    // LOAD rd=3 followed by JMP.
    applyStimulus(alu, 16'h0, 1'b0, 1'b1);
    applyStimulus(mk(OP_LOAD, 5'd3, 5'd1, 16'h0), 16'h0, 1'b0, 1'b0);
    applyStimulus(mk(OP_JMP, 5'd0, 5'd0, 16'h0020), 16'h1, 1'b0, 1'b0);
    applyStimulus(alu, 16'h2, 1'b0, 1'b0);
    check("lj_stall", 32'(stall), 32'd0);
    check("lj_sel", 32'(pc_mux_sel), 32'd1);
    check("lj_loc", 32'(jmp_loc), 32'h20);
    applyStimulus(alu, 16'h20, 1'b0, 1'b0);
    applyStimulus(alu, 16'h21, 1'b0, 1'b0);
    applyStimulus(alu, 16'h22, 1'b0, 1'b0);
    check("lj_target_pc", 32'(d_pc), 32'h20);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      bit rst;
      rst = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
      applyStimulus(randIns(), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
